axi_rd_id_remap_stage: RTL and testbench

// - AXI read-channel front end of the ROB. Sits between the master port and the slave port, and

---
 rtl/rob_pkg.sv | 28 ++
 rtl/rob_pipe_reg.sv | 40 ++++
 rtl/axi_rd_id_remap_stage.sv | 153 +++++++++++++++
 tb/tb_axi_rd_id_remap_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// rob_pkg: shared widths and beat types for the ROB read-channel front end.
//   ID_WIDTH, ADDR_WIDTH, LEN_WIDTH, DATA_WIDTH : AXI field widths.
//   MAX_OUTSTANDING : bursts in flight; CNT_W is the width of a counter that holds 0..MAX.
//   ar_beat_t : {id, addr, len} of one AR request.
//   r_beat_t  : {id, data, resp, last} of one R beat.
package rob_pkg;

  localparam int ID_WIDTH        = 4;
  localparam int ADDR_WIDTH      = 32;
  localparam int LEN_WIDTH       = 8;
  localparam int DATA_WIDTH      = 64;
  localparam int MAX_OUTSTANDING = 16;
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
  } ar_beat_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } r_beat_t;

endpackage

// File: rtl/rob_pipe_reg.sv
// rob_pipe_reg: single-entry valid/ready register with full throughput.
//   clk, rst                        : clock, synchronous active-high reset.
//   in_valid / in_ready / in_data   : upstream handshake and payload.
//   out_valid / out_ready / out_data: downstream handshake and payload.
// The entry can be refilled in the same cycle it drains, so back-to-back
// transfers run at one per cycle. The payload only changes on acceptance,
// so it holds stable while out_valid & ~out_ready.
module rob_pipe_reg #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic full_reg;
  T     data_reg;

  assign in_ready  = ~full_reg | out_ready;
  assign out_valid = full_reg;
  assign out_data  = data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      full_reg <= 1'b0;
      data_reg <= '0;
    end else if (in_valid && in_ready) begin
      full_reg <= 1'b1;
      data_reg <= in_data;
    end else if (out_ready) begin
      full_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_rd_id_remap_stage.sv
// axi_rd_id_remap_stage: AXI read-channel front end of the ROB.
//   AR: each master request obtains a unique ID from the external allocator in the
//       same cycle it is accepted, and is forwarded from a one-entry slot with that ID.
//   R : the original ID is restored on every beat via free_restored_id; the unique
//       ID is freed on the accepted RLAST beat.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset.
//   s_ar_*  (valid/ready/id/addr/len) : AR from the master.
//   m_ar_*  (valid/ready/id/addr/len) : remapped AR to the slave.
//   m_r_*   (valid/ready/id/data/resp/last) : R from the slave (unique IDs).
//   s_r_*   (valid/ready/id/data/resp/last) : R to the master (original IDs).
//   alloc_req/alloc_orig_id, alloc_gnt/alloc_unique_id/id_matrix_full : allocator.
//   free_req/free_unique_id, free_restored_id : free + combinational ID lookup.
//   outstanding_cnt, idle, err_underflow : status.
// Configuration: define R_PIPE_EN to register the R path (1 cycle latency);
// otherwise the R path is combinational.
module axi_rd_id_remap_stage
  import rob_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_ar_valid,
  output logic                  s_ar_ready,
  input  logic [ID_WIDTH-1:0]   s_ar_id,
  input  logic [ADDR_WIDTH-1:0] s_ar_addr,
  input  logic [LEN_WIDTH-1:0]  s_ar_len,
  output logic                  m_ar_valid,
  input  logic                  m_ar_ready,
  output logic [ID_WIDTH-1:0]   m_ar_id,
  output logic [ADDR_WIDTH-1:0] m_ar_addr,
  output logic [LEN_WIDTH-1:0]  m_ar_len,
  input  logic                  m_r_valid,
  output logic                  m_r_ready,
  input  logic [ID_WIDTH-1:0]   m_r_id,
  input  logic [DATA_WIDTH-1:0] m_r_data,
  input  logic [1:0]            m_r_resp,
  input  logic                  m_r_last,
  output logic                  s_r_valid,
  input  logic                  s_r_ready,
  output logic [ID_WIDTH-1:0]   s_r_id,
  output logic [DATA_WIDTH-1:0] s_r_data,
  output logic [1:0]            s_r_resp,
  output logic                  s_r_last,
  output logic                  alloc_req,
  output logic [ID_WIDTH-1:0]   alloc_orig_id,
  input  logic                  alloc_gnt,
  input  logic [ID_WIDTH-1:0]   alloc_unique_id,
  input  logic                  id_matrix_full,
  output logic                  free_req,
  output logic [ID_WIDTH-1:0]   free_unique_id,
  input  logic [ID_WIDTH-1:0]   free_restored_id,
  output logic [CNT_W-1:0]      outstanding_cnt,
  output logic                  idle,
  output logic                  err_underflow
);

  // ---------------- AR path ----------------
  logic     ar_slot_free;
  logic     ar_accept;
  ar_beat_t ar_in;
  ar_beat_t ar_out;

  // The slot's in_ready is exactly "empty or draining this cycle".
  assign alloc_req     = s_ar_valid & ar_slot_free;
  assign alloc_orig_id = s_ar_id;
  // Allocation and acceptance are the same event; a withheld grant stalls the
  // master with nothing consumed on either side.
  assign ar_accept     = alloc_req & alloc_gnt & ~id_matrix_full;
  assign s_ar_ready    = ar_accept;

  assign ar_in = '{id: alloc_unique_id, addr: s_ar_addr, len: s_ar_len};

  rob_pipe_reg #(.T(ar_beat_t)) u_ar_slot (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (ar_accept),
    .in_ready  (ar_slot_free),
    .in_data   (ar_in),
    .out_valid (m_ar_valid),
    .out_ready (m_ar_ready),
    .out_data  (ar_out)
  );

  assign m_ar_id   = ar_out.id;
  assign m_ar_addr = ar_out.addr;
  assign m_ar_len  = ar_out.len;

  // ---------------- R path ----------------
  logic r_full;

  // Lookup always tracks the incoming beat so the restored ID is valid on every beat.
  assign free_unique_id = m_r_id;
  assign free_req       = m_r_valid & m_r_ready & m_r_last;

`ifdef R_PIPE_EN
  r_beat_t r_in;
  r_beat_t r_out;

  // The restored ID is captured with the beat, so the lookup is consumed on acceptance.
  assign r_in = '{id: free_restored_id, data: m_r_data, resp: m_r_resp, last: m_r_last};

  rob_pipe_reg #(.T(r_beat_t)) u_r_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (m_r_valid),
    .in_ready  (m_r_ready),
    .in_data   (r_in),
    .out_valid (s_r_valid),
    .out_ready (s_r_ready),
    .out_data  (r_out)
  );

  assign s_r_id   = r_out.id;
  assign s_r_data = r_out.data;
  assign s_r_resp = r_out.resp;
  assign s_r_last = r_out.last;
  assign r_full   = s_r_valid;
`else
  assign s_r_valid = m_r_valid;
  assign m_r_ready = s_r_ready;
  assign s_r_id    = free_restored_id;
  assign s_r_data  = m_r_data;
  assign s_r_resp  = m_r_resp;
  assign s_r_last  = m_r_last;
  assign r_full    = 1'b0;
`endif

  // ---------------- Outstanding count ----------------
  logic [CNT_W-1:0] cnt_reg;
  logic             err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      case ({ar_accept, free_req})
        2'b10: cnt_reg <= cnt_reg + CNT_W'(1);
        2'b01: begin
          // A free with nothing outstanding is a protocol error; hold at 0.
          if (cnt_reg == '0) err_reg <= 1'b1;
          else               cnt_reg <= cnt_reg - CNT_W'(1);
        end
        default: ;  // none, or accept and free cancelling out
      endcase
    end
  end

  assign outstanding_cnt = cnt_reg;
  assign err_underflow   = err_reg;
  assign idle            = (cnt_reg == '0) & ~m_ar_valid & ~r_full;

endmodule

// File: tb/tb_axi_rd_id_remap_stage.sv
// tb_axi_rd_id_remap_stage: directed self-checking bench. The bench plays the
// allocator: it drives grants/unique IDs and answers free_restored_id from a small
// lookup table. Works with R_PIPE_EN defined or undefined.
module tb_axi_rd_id_remap_stage;
  import rob_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  s_ar_valid, s_ar_ready;
  logic [ID_WIDTH-1:0]   s_ar_id;
  logic [ADDR_WIDTH-1:0] s_ar_addr;
  logic [LEN_WIDTH-1:0]  s_ar_len;
  logic                  m_ar_valid, m_ar_ready;
  logic [ID_WIDTH-1:0]   m_ar_id;
  logic [ADDR_WIDTH-1:0] m_ar_addr;
  logic [LEN_WIDTH-1:0]  m_ar_len;
  logic                  m_r_valid, m_r_ready;
  logic [ID_WIDTH-1:0]   m_r_id;
  logic [DATA_WIDTH-1:0] m_r_data;
  logic [1:0]            m_r_resp;
  logic                  m_r_last;
  logic                  s_r_valid, s_r_ready;
  logic [ID_WIDTH-1:0]   s_r_id;
  logic [DATA_WIDTH-1:0] s_r_data;
  logic [1:0]            s_r_resp;
  logic                  s_r_last;
  logic                  alloc_req;
  logic [ID_WIDTH-1:0]   alloc_orig_id;
  logic                  alloc_gnt;
  logic [ID_WIDTH-1:0]   alloc_unique_id;
  logic                  id_matrix_full;
  logic                  free_req;
  logic [ID_WIDTH-1:0]   free_unique_id;
  logic [ID_WIDTH-1:0]   free_restored_id;
  logic [CNT_W-1:0]      outstanding_cnt;
  logic                  idle, err_underflow;

  logic [ID_WIDTH-1:0] id_tbl [16];
  int checks = 0;
  int errors = 0;

  assign free_restored_id = id_tbl[free_unique_id];

  always #5 clk = ~clk;

  axi_rd_id_remap_stage dut (
    .clk(clk), .rst(rst),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_id(s_ar_id),
    .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_id(m_ar_id),
    .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_id(m_r_id),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_last(m_r_last),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .alloc_req(alloc_req), .alloc_orig_id(alloc_orig_id), .alloc_gnt(alloc_gnt),
    .alloc_unique_id(alloc_unique_id), .id_matrix_full(id_matrix_full),
    .free_req(free_req), .free_unique_id(free_unique_id),
    .free_restored_id(free_restored_id),
    .outstanding_cnt(outstanding_cnt), .idle(idle), .err_underflow(err_underflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; land 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ar(input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [3:0] uid);
    s_ar_valid = 1'b1; s_ar_id = id; s_ar_addr = addr; s_ar_len = len;
    alloc_gnt = 1'b1; alloc_unique_id = uid;
  endtask

  task automatic check_s_r(input logic [3:0] exp_id, input logic [63:0] d, input logic last);
    check("s_r_valid", s_r_valid, 1'b1);
    check("s_r_id", s_r_id, exp_id);
    check("s_r_data", s_r_data, d);
    check("s_r_resp", s_r_resp, d[1:0]);
    check("s_r_last", s_r_last, last);
  endtask

  // One R beat from the slave, accepted in one cycle (s_r_ready is high).
  task automatic r_beat(input logic [3:0] uid, input logic [63:0] d,
                        input logic last, input logic [3:0] exp_id);
    m_r_valid = 1'b1; m_r_id = uid; m_r_data = d; m_r_resp = d[1:0]; m_r_last = last;
    #1;
    check("free_req", free_req, last);
    check("free_uid", free_unique_id, uid);
`ifndef R_PIPE_EN
    check_s_r(exp_id, d, last);
`endif
    tick();
`ifdef R_PIPE_EN
    check_s_r(exp_id, d, last);
`endif
    m_r_valid = 1'b0; m_r_last = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) id_tbl[i] = 4'(i);
    rst = 1'b1;
    s_ar_valid = 0; s_ar_id = 0; s_ar_addr = 0; s_ar_len = 0;
    m_ar_ready = 0; m_r_valid = 0; m_r_id = 0; m_r_data = 0; m_r_resp = 0; m_r_last = 0;
    s_r_ready = 1; alloc_gnt = 0; alloc_unique_id = 0; id_matrix_full = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    // ---- reset state ----
    check("rst m_ar_valid", m_ar_valid, 0);
    check("rst s_r_valid", s_r_valid, 0);
    check("rst cnt", outstanding_cnt, 0);
    check("rst err", err_underflow, 0);
    check("rst idle", idle, 1);
    check("rst m_ar_id", m_ar_id, 0);

    // ---- single read: id 7 -> unique 0, 4 beats ----
    id_tbl[0] = 4'h7;
    drive_ar(4'h7, 32'h1000, 8'd3, 4'h0);
    #1;
    check("t1 alloc_req", alloc_req, 1);
    check("t1 alloc_orig", alloc_orig_id, 4'h7);
    check("t1 s_ar_ready", s_ar_ready, 1);
    check("t1 cnt0", outstanding_cnt, 0);
    tick();
    s_ar_valid = 0; alloc_gnt = 0;
    check("t1 m_ar_valid", m_ar_valid, 1);
    check("t1 m_ar_id", m_ar_id, 4'h0);
    check("t1 m_ar_addr", m_ar_addr, 32'h1000);
    check("t1 m_ar_len", m_ar_len, 8'd3);
    check("t1 cnt1", outstanding_cnt, 1);
    check("t1 idle", idle, 0);
    m_ar_ready = 1;
    tick();
    m_ar_ready = 0;
    check("t1 m_ar drained", m_ar_valid, 0);
    for (int b = 0; b < 4; b++)
      r_beat(4'h0, 64'hA500 + 64'(b), (b == 3), 4'h7);
    tick();
    check("t1 cnt end", outstanding_cnt, 0);
    check("t1 idle end", idle, 1);

    // ---- backpressure: slot held, second AR stalls ----
    drive_ar(4'h3, 32'h2000, 8'd1, 4'h1);
    tick();
    drive_ar(4'h5, 32'h3000, 8'd0, 4'h2);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp s_ar_ready", s_ar_ready, 0);
      check("bp alloc_req", alloc_req, 0);
      check("bp m_ar_id", m_ar_id, 4'h1);
      check("bp m_ar_addr", m_ar_addr, 32'h2000);
      tick();
    end
    check("bp cnt", outstanding_cnt, 1);
    m_ar_ready = 1;
    #1;
    check("bp release alloc_req", alloc_req, 1);
    check("bp release s_ar_ready", s_ar_ready, 1);
    tick();
    s_ar_valid = 0; alloc_gnt = 0;
    check("bp second m_ar_id", m_ar_id, 4'h2);
    check("bp second addr", m_ar_addr, 32'h3000);
    check("bp cnt2", outstanding_cnt, 2);
    tick();
    check("bp drained", m_ar_valid, 0);

    // ---- full: allocator refuses, then grants ----
    drive_ar(4'h9, 32'h4000, 8'd0, 4'h3);
    alloc_gnt = 0; id_matrix_full = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("full s_ar_ready", s_ar_ready, 0);
      tick();
    end
    check("full cnt", outstanding_cnt, 2);
    check("full m_ar_valid", m_ar_valid, 0);
    id_matrix_full = 0; alloc_gnt = 1;
    #1;
    check("full grant s_ar_ready", s_ar_ready, 1);
    tick();
    s_ar_valid = 0; alloc_gnt = 0;
    check("full cnt3", outstanding_cnt, 3);
    check("full m_ar_id", m_ar_id, 4'h3);

    // ---- same-cycle accept + RLAST free at cnt=3 ----
    id_tbl[1] = 4'h3;
    drive_ar(4'hA, 32'h5000, 8'd0, 4'h4);
    m_r_valid = 1; m_r_id = 4'h1; m_r_data = 64'h55; m_r_resp = 2'b01; m_r_last = 1;
    #1;
    check("same alloc_req", alloc_req, 1);
    check("same s_ar_ready", s_ar_ready, 1);
    check("same free_req", free_req, 1);
    tick();
    s_ar_valid = 0; alloc_gnt = 0; m_r_valid = 0; m_r_last = 0;
    check("same cnt", outstanding_cnt, 3);
    check("same m_ar_id", m_ar_id, 4'h4);
    tick();
    m_ar_ready = 0;
    // drain the three remaining bursts with single-beat RLASTs
    r_beat(4'h2, 64'h10, 1'b1, 4'h2);
    r_beat(4'h3, 64'h21, 1'b1, 4'h3);
    r_beat(4'h4, 64'h32, 1'b1, 4'h4);
    check("drain cnt", outstanding_cnt, 0);
    check("drain err", err_underflow, 0);

    // ---- underflow ----
    r_beat(4'h6, 64'h43, 1'b1, 4'h6);
    check("uf err", err_underflow, 1);
    check("uf cnt", outstanding_cnt, 0);
    tick(); tick();
    check("uf sticky", err_underflow, 1);
    check("uf cnt held", outstanding_cnt, 0);

    // ---- mid-burst reset: AR waiting in slot, beat 2 of 4 ----
    drive_ar(4'h6, 32'h6000, 8'd3, 4'h5);
    tick();
    s_ar_valid = 0; alloc_gnt = 0;
    check("mr m_ar_valid", m_ar_valid, 1);
    check("mr cnt", outstanding_cnt, 1);
    id_tbl[5] = 4'h6;
    r_beat(4'h5, 64'h60, 1'b0, 4'h6);
    m_r_valid = 1; m_r_id = 4'h5; m_r_data = 64'h61; m_r_last = 0;
    rst = 1;
    tick();
    rst = 0; m_r_valid = 0;
    check("mr m_ar_valid0", m_ar_valid, 0);
    check("mr s_r_valid0", s_r_valid, 0);
    check("mr idle", idle, 1);
    check("mr cnt0", outstanding_cnt, 0);
    check("mr err cleared", err_underflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1);
  end

endmodule
